// File: rtl/eth_rx_cmd_pkg.sv
// Shared types and constants for the Ethernet RX command decoder.
package eth_rx_cmd_pkg;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    PAY   = 2'd1,
    ISSUE = 2'd2,
    DROP  = 2'd3
  } state_e;

  localparam int          ETH_HDR_LEN       = 14;
  localparam int          CMD_REC_LEN       = 3;
  localparam logic [7:0]  CMD_NOP_ADDR      = 8'h00;
  localparam logic [15:0] ETHERTYPE_DEFAULT = 16'h88B5;

  // Byte idx (0 = first on the wire) of a 48-bit MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    case (idx)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      3'd5:    return mac[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/eth_rx_cmd_decoder_sat_counter16.sv
// 16-bit event counter that sticks at its maximum value.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  // Next count: step on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= 16'h0000;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/eth_rx_cmd_decoder.sv
// Filters received Ethernet frames by destination MAC / EtherType and turns
// the payload into 3-byte register-write records on a valid/ready port.
module eth_rx_cmd_decoder
  import eth_rx_cmd_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] local_mac,
  input  logic [7:0]  rx_axis_fifo_tdata,
  input  logic        rx_axis_fifo_tvalid,
  output logic        rx_axis_fifo_tready,
  input  logic        rx_axis_fifo_tlast,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  localparam logic [3:0] LAST_HDR_BYTE = 4'(ETH_HDR_LEN - 1);
  localparam logic [1:0] LAST_REC_BYTE = 2'(CMD_REC_LEN - 1);

  state_e      state_q, state_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  rec_idx_q, rec_idx_d;
  logic        ucast_ok_q, ucast_ok_d;
  logic        bcast_ok_q, bcast_ok_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_hi_q, data_hi_d;
  logic        last_q, last_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_data_q, cmd_data_d;

  logic xfer, hdr_ok, ucast_hit, bcast_hit, issue_now, frame_inc, drop_inc;

  // tready depends only on registered state (plus reset).
  assign rx_axis_fifo_tready = !reset && (state_q != ISSUE);
  assign xfer = rx_axis_fifo_tvalid && rx_axis_fifo_tready;

  // Per-byte header check. The match flags only carry history from byte 1 on,
  // so byte 0 never depends on the previous frame.
  always_comb begin
    ucast_hit = 1'b0;
    bcast_hit = 1'b0;
    hdr_ok    = 1'b1;
    if (byte_cnt_q < 4'd6) begin
      ucast_hit = (ucast_ok_q || (byte_cnt_q == 4'd0)) &&
                  (rx_axis_fifo_tdata == mac_byte(local_mac, byte_cnt_q[2:0]));
      bcast_hit = (bcast_ok_q || (byte_cnt_q == 4'd0)) && (rx_axis_fifo_tdata == 8'hFF);
      hdr_ok    = ucast_hit || bcast_hit;
    end else if (byte_cnt_q == 4'd12) begin
      hdr_ok = (rx_axis_fifo_tdata == ETHERTYPE[15:8]);
    end else if (byte_cnt_q == LAST_HDR_BYTE) begin
      hdr_ok = (rx_axis_fifo_tdata == ETHERTYPE[7:0]);
    end
  end

  // Next-state and datapath logic for the frame FSM.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    rec_idx_d   = rec_idx_q;
    ucast_ok_d  = ucast_ok_q;
    bcast_ok_d  = bcast_ok_q;
    addr_d      = addr_q;
    data_hi_d   = data_hi_q;
    last_d      = last_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    issue_now   = 1'b0;
    frame_inc   = 1'b0;
    drop_inc    = 1'b0;

    case (state_q)
      HDR: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q < 4'd6) begin
            ucast_ok_d = ucast_hit;
            bcast_ok_d = bcast_hit;
          end
          if (!hdr_ok) begin
            // One drop per frame: decided here, the rest is swallowed in DROP.
            drop_inc   = 1'b1;
            byte_cnt_d = 4'd0;
            state_d    = rx_axis_fifo_tlast ? HDR : DROP;
          end else if (byte_cnt_q == LAST_HDR_BYTE) begin
            byte_cnt_d = 4'd0;
            rec_idx_d  = 2'd0;
            if (rx_axis_fifo_tlast) frame_inc = 1'b1;
            else                    state_d   = PAY;
          end else if (rx_axis_fifo_tlast) begin
            // Runt frame.
            drop_inc   = 1'b1;
            byte_cnt_d = 4'd0;
          end
        end
      end

      PAY: begin
        if (xfer) begin
          if (rec_idx_q == 2'd0) begin
            addr_d    = rx_axis_fifo_tdata;
            rec_idx_d = 2'd1;
          end else if (rec_idx_q == 2'd1) begin
            data_hi_d = rx_axis_fifo_tdata;
            rec_idx_d = LAST_REC_BYTE;
          end else begin
            rec_idx_d = 2'd0;
            last_d    = rx_axis_fifo_tlast;
            if (addr_q != CMD_NOP_ADDR) begin
              issue_now   = 1'b1;
              cmd_addr_d  = addr_q;
              cmd_data_d  = {data_hi_q, rx_axis_fifo_tdata};
              cmd_valid_d = 1'b1;
              state_d     = ISSUE;
            end
          end
          // Frame end without a pending command; a partial record is discarded.
          if (rx_axis_fifo_tlast && !issue_now) begin
            frame_inc = 1'b1;
            rec_idx_d = 2'd0;
            state_d   = HDR;
          end
        end
      end

      ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (last_q) begin
            frame_inc = 1'b1;
            state_d   = HDR;
          end else begin
            state_d = PAY;
          end
        end
      end

      DROP: begin
        if (xfer && rx_axis_fifo_tlast) state_d = HDR;
      end

      default: state_d = HDR;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HDR;
      byte_cnt_q  <= 4'd0;
      rec_idx_q   <= 2'd0;
      ucast_ok_q  <= 1'b0;
      bcast_ok_q  <= 1'b0;
      addr_q      <= 8'h00;
      data_hi_q   <= 8'h00;
      last_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= 8'h00;
      cmd_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      rec_idx_q   <= rec_idx_d;
      ucast_ok_q  <= ucast_ok_d;
      bcast_ok_q  <= bcast_ok_d;
      addr_q      <= addr_d;
      data_hi_q   <= data_hi_d;
      last_q      <= last_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;

  sat_counter16 u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (frame_inc),
    .count (frame_count)
  );

  sat_counter16 u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .count (drop_count)
  );

endmodule
